adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle adder.
- Adds two WIDTH-bit operands per transaction, with per-transaction signed/unsigned mode.
- Overflow can wrap or saturate (selected by parameter).
- Uses valid/ready handshakes on both input and output, with per-stage backpressure and bubble collapse.
- Sits between the stimulus driver and the scoreboard/consumer in the adder environment.
- Also counts completed results.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- STAGES, 2, pipeline depth = latency in cycles with no stalls (>=1).
- SAT, 0, 0 = wrap on overflow; 1 = saturate on overflow.
- COUNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement add; 0 = unsigned add.
- valid  in  1  input transaction valid.
- ready  out  1  block can accept an input this cycle.
- c  out  WIDTH  result.
- overflow  out  1  result overflowed (flag is set whether wrapped or saturated).
- c_valid  out  1  c/overflow hold a valid result.
- c_ready  in  1  consumer accepts the result.
- txn_count  out  COUNT_W  number of completed output handshakes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0), applied immediately regardless of clk:
  - all stage valid bits = 0; c = 0; overflow = 0; c_valid = 0; txn_count = 0.
  - ready drives 1 while in reset, since all stages are empty.
  - Reset mid-operation discards all in-flight results; none reappear after release.
- Input handshake: fires when valid && ready; a, b and is_signed are sampled on that edge.
- Output handshake: fires when c_valid && c_ready.
- Stage 0 computation on the input handshake:
  - Computes sum = a + b at WIDTH+1 bits.
  - Unsigned: ovf = carry-out.
  - Signed: ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - SAT=0: result = sum[WIDTH-1:0].
  - SAT=1 and ovf:
    - unsigned result = all ones;
    - signed result = max positive (0111..1) if a[MSB]=0, else min negative (1000..0).
  - The result and ovf are registered into stage 0.
- Stages 1..STAGES-1 pass {result, ovf} through unchanged.
- Stage k holds {vk, data}. Stage k loads from k-1 when (!vk || advance_{k+1}).
  - Last stage: advance = c_ready.
  - ready = !v0 || advance_1. For STAGES=1, ready = !v0 || c_ready.
- Bubble collapse: an empty stage accepts even when downstream is stalled.
  - Stall-free latency: input handshake at edge N gives c_valid=1 after edge N+STAGES-1, i.e. first visible in the cycle after edge N+STAGES-1.
  - Full throughput: 1 transaction/cycle.
- c, overflow and c_valid are registered outputs of the last stage.
  - While c_valid=1 && c_ready=0, c and overflow hold stable.
- No combinational path from valid, a or b to any output.
- Combinational path from c_ready to ready is permitted.
- Simultaneous input and output handshake on a full pipeline:
  - both fire;
  - occupancy is unchanged; no data is lost or duplicated.
- Pipeline full (all vk=1) and c_ready=0: ready = 0. Inputs presented then are not consumed.
- txn_count increments by 1 per output handshake and wraps 2^COUNT_W-1 -> 0.
- Ordering is strictly FIFO.

Test Plan (WIDTH=8, STAGES=2 unless noted):
1. SAT=0, unsigned, a=200 b=100, c_ready=1 -> c=44 (0x2C), overflow=1, c_valid 2 cycles after handshake; a=3 b=4 -> c=7, overflow=0.
2. SAT=1:
   - unsigned 200+100 -> c=255, overflow=1;
   - signed 100+100 -> c=127 (0x7F), overflow=1;
   - signed -100+-100 -> c=0x80, overflow=1;
   - signed 100+-100 -> c=0, overflow=0.
3. Backpressure:
   - stream 0+1, 0+2, 0+3, 0+4 with c_ready=0 -> ready drops after 2 accepts;
   - c=1 held stable;
   - release c_ready -> outputs 1,2,3,4 in order, no gaps once flowing;
   - txn_count=4.
4. Random valid/c_ready toggling, 1000 transactions, both modes -> scoreboard match; txn_count=1000 mod 2^COUNT_W.
5. Reset asserted asynchronously with 2 results in flight -> c_valid=0, c=0, txn_count=0 immediately; no stale result after release.
6. COUNT_W=4: 17 transactions -> txn_count wraps to 1.
7. STAGES=1 back-to-back handshakes -> latency 1, 1/cycle throughput.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit adder with per-transaction signed/unsigned
// mode, wrap or saturate on overflow, valid/ready on both sides with
// per-stage backpressure and bubble collapse, and a completed-result counter.
module adder_pipe #(
   parameter int WIDTH   = 8,
   parameter int STAGES  = 2,
   parameter int SAT     = 0,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic               valid,
   output logic               ready,
   output logic [WIDTH-1:0]   c,
   output logic               overflow,
   output logic               c_valid,
   input  logic               c_ready,
   output logic [COUNT_W-1:0] txn_count
);

   // Stage payload: {ovf, result}
   typedef logic [WIDTH:0] word_t;

   logic [STAGES-1:0] v;
   word_t             d [STAGES];
   logic [STAGES-1:0] adv;

   logic [WIDTH:0]    sum;
   logic              ovf;
   logic [WIDTH-1:0]  res;
   logic              full;

   // Stage-0 arithmetic: full-width sum, overflow detect, optional saturation
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      if (is_signed)
         ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      else
         ovf = sum[WIDTH];
      res = sum[WIDTH-1:0];
      if (SAT != 0 && ovf) begin
         if (!is_signed)
            res = '1;
         else if (a[WIDTH-1])
            res = {1'b1, {(WIDTH-1){1'b0}}};
         else
            res = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   // Per-stage load enables. The recursive chain adv[k] = !v[k] || adv[k+1]
   // is flattened to "not every stage from k to the end is full, or the
   // consumer is taking the last one", which avoids a self-referencing vector.
   always_comb begin
      full = 1'b1;
      adv  = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         full = 1'b1;
         for (int unsigned j = k; j < STAGES; j++)
            full = full & v[j];
         adv[k] = !full || c_ready;
      end
   end

   assign ready    = adv[0];
   assign c        = d[STAGES-1][WIDTH-1:0];
   assign overflow = d[STAGES-1][WIDTH];
   assign c_valid  = v[STAGES-1];

   // Pipeline registers: each stage loads from its predecessor when it is
   // empty or its own content moves on; payload only updates on valid data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v <= '0;
         for (int unsigned k = 0; k < STAGES; k++)
            d[k] <= '0;
      end else begin
         if (adv[0]) begin
            v[0] <= valid;
            if (valid)
               d[0] <= {ovf, res};
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               v[k] <= v[k-1];
               if (v[k-1])
                  d[k] <= d[k-1];
            end
         end
      end
   end

   // Completed output handshakes, wrapping at 2^COUNT_W
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         txn_count <= '0;
      else if (c_valid && c_ready)
         txn_count <= txn_count + 1'b1;
   end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe. u0 is WIDTH=8, STAGES=2,
// SAT=0, COUNT_W=16; u1 is WIDTH=8, STAGES=1, SAT=1, COUNT_W=4.
module tb_adder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   logic [7:0]  a0 = '0, b0 = '0, c0;
   logic        s0 = 1'b0, v0 = 1'b0, cr0 = 1'b1, r0, o0, cv0;
   logic [15:0] cnt0;

   logic [7:0]  a1 = '0, b1 = '0, c1;
   logic        s1 = 1'b0, v1 = 1'b0, cr1 = 1'b1, r1, o1, cv1;
   logic [3:0]  cnt1;

   int errors = 0;
   int checks = 0;
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   bit rand_cr = 1'b0;

   adder_pipe #(.WIDTH(8), .STAGES(2), .SAT(0), .COUNT_W(16)) u0 (
      .clk(clk), .reset(rst_n), .a(a0), .b(b0), .is_signed(s0), .valid(v0),
      .ready(r0), .c(c0), .overflow(o0), .c_valid(cv0), .c_ready(cr0),
      .txn_count(cnt0));

   adder_pipe #(.WIDTH(8), .STAGES(1), .SAT(1), .COUNT_W(4)) u1 (
      .clk(clk), .reset(rst_n), .a(a1), .b(b1), .is_signed(s1), .valid(v1),
      .ready(r1), .c(c1), .overflow(o1), .c_valid(cv1), .c_ready(cr1),
      .txn_count(cnt1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic with explicit range checks
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic s, input bit sat);
      int x;
      logic ov;
      logic [7:0] r;
      if (s) x = int'($signed(a)) + int'($signed(b));
      else   x = int'(a) + int'(b);
      if (s) ov = (x > 127) || (x < -128);
      else   ov = (x > 255);
      r = x[7:0];
      if (sat && ov) r = s ? ((x > 0) ? 8'h7F : 8'h80) : 8'hFF;
      return {ov, r};
   endfunction

   // Output monitors: compare whenever an output handshake is about to fire
   always @(negedge clk) begin
      if (rst_n && cv0 && cr0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL out0_unexpected: got c=%0h ovf=%0b, expected no output", c0, o0);
         end else
            chk("out0", {o0, c0}, q0.pop_front());
      end
      if (rst_n && cv1 && cr1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL out1_unexpected: got c=%0h ovf=%0b, expected no output", c1, o1);
         end else
            chk("out1", {o1, c1}, q1.pop_front());
      end
   end

   // Random consumer backpressure on u0 when enabled
   always @(posedge clk) begin
      #1;
      if (rand_cr) cr0 = 1'($urandom_range(0, 1));
   end

   // Issue one transaction to unit u; expected response queued on acceptance
   task automatic send(input int u, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [8:0] e);
      int n = 0;
      logic rdy;
      if (u == 0) begin a0 = a; b0 = b; s0 = s; v0 = 1'b1; end
      else        begin a1 = a; b1 = b; s1 = s; v1 = 1'b1; end
      @(negedge clk);
      rdy = (u == 0) ? r0 : r1;
      while (!rdy && n < 200) begin
         @(negedge clk);
         rdy = (u == 0) ? r0 : r1;
         n++;
      end
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL send_timeout: unit %0d ready stayed 0, expected 1", u);
      end else if (u == 0) q0.push_back(e);
      else                 q1.push_back(e);
      @(posedge clk);
      #1;
      if (u == 0) v0 = 1'b0; else v1 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: pending %0d/%0d, expected 0/0", q0.size(), q1.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", r0, 1);
      chk("rst_cvalid", cv0, 0);
      chk("rst_c", c0, 0);
      chk("rst_ovf", o0, 0);
      chk("rst_cnt", cnt0, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: unsigned wrap, latency 2
      a0 = 8'd200; b0 = 8'd100; s0 = 1'b0; v0 = 1'b1;
      @(negedge clk);
      chk("t1_ready", r0, 1);
      @(posedge clk);
      q0.push_back(9'h12C);
      #1 v0 = 1'b0;
      chk("t1_lat_edgeN", cv0, 0);
      @(posedge clk);
      #1;
      chk("t1_lat_edgeN1", cv0, 1);
      chk("t1_c", c0, 8'h2C);
      chk("t1_ovf", o0, 1);
      send(0, 8'd3, 8'd4, 1'b0, 9'h007);
      drain();

      // 2: saturation on u1
      send(1, 8'd200, 8'd100, 1'b0, 9'h1FF);
      send(1, 8'd100, 8'd100, 1'b1, 9'h17F);
      send(1, 8'h9C, 8'h9C, 1'b1, 9'h180);
      send(1, 8'd100, 8'h9C, 1'b1, 9'h000);
      drain();

      // 3: backpressure
      do_reset();
      cr0 = 1'b0;
      fork
         begin
            send(0, 8'd0, 8'd1, 1'b0, 9'd1);
            send(0, 8'd0, 8'd2, 1'b0, 9'd2);
            send(0, 8'd0, 8'd3, 1'b0, 9'd3);
            send(0, 8'd0, 8'd4, 1'b0, 9'd4);
         end
         begin
            repeat (5) @(negedge clk);
            chk("t3_ready_low", r0, 0);
            chk("t3_accepts", q0.size(), 2);
            chk("t3_cvalid", cv0, 1);
            chk("t3_c_hold0", c0, 1);
            @(negedge clk);
            chk("t3_c_hold1", c0, 1);
            @(posedge clk);
            #1 cr0 = 1'b1;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk("t3_no_gap", cv0, 1);
            end
         end
      join
      drain();
      chk("t3_cnt", cnt0, 4);

      // 4: random traffic, both modes, random consumer stalls
      do_reset();
      rand_cr = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic rs;
         int gap;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         gap = $urandom_range(0, 3);
         if (gap > 1) begin
            repeat (gap - 1) @(posedge clk);
            #1;
         end
         send(0, ra, rb, rs, model(ra, rb, rs, 1'b0));
      end
      rand_cr = 1'b0;
      @(posedge clk);
      #2 cr0 = 1'b1;
      drain();
      chk("t4_cnt", cnt0, 1000);

      // 5: async reset with two results in flight
      cr0 = 1'b0;
      send(0, 8'd5, 8'd6, 1'b0, 9'd11);
      send(0, 8'd7, 8'd8, 1'b0, 9'd15);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_cvalid", cv0, 0);
      chk("t5_c", c0, 0);
      chk("t5_cnt", cnt0, 0);
      chk("t5_ready", r0, 1);
      q0.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      cr0 = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t5_no_stale", cv0, 0);
      end

      // 6: 4-bit counter wraps after 17 results
      do_reset();
      for (int i = 0; i < 17; i++)
         send(1, 8'(i), 8'd1, 1'b0, model(8'(i), 8'd1, 1'b0, 1'b1));
      drain();
      chk("t6_cnt_wrap", cnt1, 1);

      // 7: STAGES=1 back-to-back, latency 1
      @(posedge clk);
      #1;
      a1 = 8'd10; b1 = 8'd20; s1 = 1'b0; v1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t7_ready", r1, 1);
         @(posedge clk);
         q1.push_back({1'b0, 8'(30 + k)});
         #1;
         chk("t7_latency", cv1, 1);
         chk("t7_c", c1, 30 + k);
         a1 = a1 + 8'd1;
      end
      v1 = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
